theta_sequencer: RTL
====================

THETA_SEQUENCER -- requirements
Module: theta_sequencer

Interface
REQ-001 SHALL have parameter SLICES, default 64: number of 25-bit slices in the state memory, at least 2.
REQ-002 SHALL have parameter AW, default 6: slice address width, with 2^AW >= SLICES.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request one column-parity pass over the whole state.
REQ-006 SHALL have port busy, output, 1 bit: high while a pass is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.
REQ-008 SHALL have port rd_en, output, 1 bit: state-memory read strobe.
REQ-009 SHALL have port rd_addr, output, AW bits: slice index to read.
REQ-010 SHALL have port rd_data, input, 25 bits: slice contents, valid exactly 1 cycle after the rd_en cycle.
REQ-011 SHALL have port wr_en, output, 1 bit: state-memory write strobe.
REQ-012 SHALL have port wr_addr, output, AW bits: slice index to write.
REQ-013 SHALL have port wr_data, output, 25 bits: updated slice.

Function
REQ-014 SHALL instantiate one colParity datapath; input1 = previous-slice register, input2 = current slice (rd_data).
REQ-015 SHALL implement FSM states IDLE, PRIME, RUN, FLUSH, DONE.
REQ-016 IDLE: busy=0; start=1 -> PRIME. Start SHALL be ignored in all other states.
REQ-017 PRIME, 1 cycle: rd_en=1, rd_addr=SLICES-1 (wrap-around predecessor of slice 0); -> RUN.
REQ-018 RUN, SLICES cycles: rd_en=1, rd_addr = 0, 1, ..., SLICES-1 in consecutive cycles.
REQ-019 Entry cycle of RUN: prev register SHALL capture rd_data (original slice SLICES-1); no write occurs.
REQ-020 Each later RUN cycle, and the FLUSH cycle: wr_en=1, wr_addr = k, wr_data = colParity(prev, rd_data), where k = previous read address; prev SHALL then capture rd_data.
REQ-021 FLUSH, 1 cycle: rd_en=0; writes slice SLICES-1; -> DONE.
REQ-022 DONE, 1 cycle: done=1, busy=0; -> IDLE. A start asserted in DONE SHALL be ignored.
REQ-023 Latency: start sampled at edge 0; writes of slice k occur in cycle k+3; done=1 in cycle SLICES+3. Total SLICES+3 cycles start-to-done.
REQ-024 Updates SHALL be in place: each prev value is the original, pre-pass slice content. No slice SHALL be read after it is written within a pass.
REQ-025 busy SHALL be 1 in PRIME, RUN and FLUSH, and 0 otherwise.
REQ-026 rd_en and wr_en SHALL never be high in IDLE or DONE.
REQ-027 wr_en SHALL be high exactly SLICES times per pass, once per address.
REQ-028 Address counters SHALL not wrap past SLICES-1 within a pass.

Reset
REQ-029 While rst=1: state=IDLE; busy, done, rd_en and wr_en = 0; rd_addr, wr_addr, wr_data and prev = 0.
REQ-030 Reset asserted mid-pass SHALL abort immediately with no further writes; the next start SHALL run a complete pass.

Verification
REQ-031 All-zero memory, start pulse -> 64 writes of 0x0000000 to addresses 0..63 in cycles 3..66; done=1 in cycle 67 only.
REQ-032 Only slice 0 = 0x0000001 -> slice 0 written 0x0210843, slice 1 written 0x1084210, all other slices 0.
REQ-033 Only slice 63 = 0x0000001 (wrap-around) -> slice 63 written 0x0210843, slice 0 written 0x1084210, others 0.
REQ-034 start held high for 100 cycles -> exactly one pass runs; a second pass starts at the first start sampled in IDLE after done.
REQ-035 rst pulsed in cycle 20 of a pass -> wr_en=0 from the reset edge onward; busy=0; a fresh start then gives a correct full pass against a reference model.
REQ-036 Random memory contents, SLICES=64 and SLICES=5 -> every written slice matches the software theta column-parity model; rd_en/wr_en counts per pass = 65/64 and 6/5 respectively.

Source files
------------

// File: rtl/theta_sequencer.sv
// Column-parity (theta) pass over a slice-organised 5x5xSLICES state memory.
// Reads each slice once, writes it back in place one cycle later.

module theta_col_parity (
    input  logic [24:0] prev,
    input  logic [24:0] cur,
    output logic [24:0] result
);
    logic [4:0] par_prev;
    logic [4:0] par_cur;

    // bit index x + 5*y; column x parity of slice z-1 enters at x-1, of slice z at x+1
    always_comb begin
        par_prev = '0;
        par_cur  = '0;
        result   = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                par_prev[x] = par_prev[x] ^ prev[x + 5*y];
                par_cur[x]  = par_cur[x] ^ cur[x + 5*y];
            end
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                result[x + 5*y] = cur[x + 5*y] ^ par_cur[(x + 4) % 5] ^ par_prev[(x + 1) % 5];
            end
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for start
// PRIME | read slice SLICES-1 as the wrap-around predecessor of slice 0
// RUN   | read slice cnt, write slice cnt-1 (no write on entry)
// FLUSH | write the last slice
// DONE  | one-cycle completion pulse
module theta_sequencer #(
    parameter int SLICES = 64,
    parameter int AW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [24:0]   rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [24:0]   wr_data
);
    typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(SLICES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [24:0]   prev_slice;
    logic [24:0]   parity;

    theta_col_parity u_col_parity (
        .prev   (prev_slice),
        .cur    (rd_data),
        .result (parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            prev_slice <= '0;
        end else begin
            if (state == RUN && cnt != LAST) cnt <= cnt + AW'(1);
            else                             cnt <= '0;
            if (state == RUN || state == FLUSH) prev_slice <= rd_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PRIME;
            PRIME:   state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            PRIME: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = LAST;
            end
            RUN: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = cnt;
                if (cnt != '0) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt - AW'(1);
                    wr_data = parity;
                end
            end
            FLUSH: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = LAST;
                wr_data = parity;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end
endmodule
